// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO in front of data_mem. Loads forward from the
// youngest matching buffered store or read data_mem with one-cycle latency.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_data,
  output logic              sb_empty,
  output logic              dwe,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    SRC_MEM = 1'b0,
    SRC_FWD = 1'b1
  } ld_src_e;

  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [ADDR_W-1:0] ent_addr_d [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ld_done_q, ld_done_d;
  ld_src_e           ld_src_q, ld_src_d;
  logic [DATA_W-1:0] fwd_q, fwd_d;

  logic              full, empty, hit, push, pop, drain;
  logic [DATA_W-1:0] hit_data;
  logic [PTR_W-1:0]  idx;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign sb_empty = empty;
  assign ld_done  = ld_done_q;
  assign ld_data  = ld_done_q ? ((ld_src_q == SRC_FWD) ? fwd_q : rdata) : '0;

  // Forwarding lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (ent_addr_q[idx] == ld_addr)) begin
        hit      = 1'b1;
        hit_data = ent_data_q[idx];
      end
    end
  end

  // Port arbitration: one data_mem access per cycle; a full buffer forces a drain.
  // dwe is masked during reset so discarded stores never reach data_mem.
  always_comb begin
    drain    = 1'b0;
    addr     = '0;
    wdata    = '0;
    ld_ready = !(full && !hit);
    if (ld_valid && !hit && full) begin
      drain = 1'b1;
    end else if (ld_valid && !hit) begin
      addr = ld_addr;
    end else if (ld_valid && hit) begin
      drain = !empty;
    end else begin
      drain = !empty;
    end
    if (drain) begin
      addr  = ent_addr_q[rd_ptr_q];
      wdata = ent_data_q[rd_ptr_q];
    end
    dwe = drain && reset;
  end

  // FIFO next state: push at tail, pop head when draining.
  always_comb begin
    push       = st_valid && st_ready;
    pop        = drain;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      ent_addr_d[wr_ptr_q] = st_addr;
      ent_data_d[wr_ptr_q] = st_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Load return: capture source and forwarded word at acceptance.
  always_comb begin
    ld_done_d = ld_valid && ld_ready;
    ld_src_d  = hit ? SRC_FWD : SRC_MEM;
    fwd_d     = hit_data;
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge mem_clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ld_done_q <= 1'b0;
      ld_src_q  <= SRC_MEM;
      fwd_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ld_done_q <= ld_done_d;
      ld_src_q  <= ld_src_d;
      fwd_q     <= fwd_d;
    end
  end

  // Entry storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge mem_clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

endmodule
